// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: display fetch owns the single SRAM port inside the
// fetch window; buffered host writes drain whenever the display does not need it.
module vga_fb_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 24,
  parameter int H_ACT_START = 140,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 34,
  parameter int V_ACT       = 480,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [9:0]        iH_Cont,
  input  logic [9:0]        iV_Cont,
  input  logic              iWr_valid,
  output logic              oWr_ready,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic [DATA_W-1:0] iWr_data,
  output logic [ADDR_W-1:0] oMem_addr,
  output logic              oMem_we,
  output logic [DATA_W-1:0] oMem_wdata,
  input  logic [DATA_W-1:0] iMem_rdata,
  output logic [7:0]        oRed,
  output logic [7:0]        oGreen,
  output logic [7:0]        oBlue,
  output logic [2:0]        oFifo_level,
  output logic [7:0]        oFrame_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Fetch runs three pixels ahead: address register, SRAM latency, colour register.
  localparam logic [9:0] H_WIN_LO = 10'(H_ACT_START - 3);
  localparam logic [9:0] H_WIN_HI = 10'(H_ACT_START - 3 + H_ACT);
  localparam logic [9:0] V_WIN_LO = 10'(V_ACT_START);
  localparam logic [9:0] V_WIN_HI = 10'(V_ACT_START + V_ACT);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [1:0]        state, nextState;
  logic              inWin, push, pop, fetchD1;
  logic [ADDR_W-1:0] hRel, vRel, fetchAddr;
  logic [DATA_W-1:0] pixel;
  logic [9:0]        vPrev;

  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoData [FIFO_DEPTH];

  assign inWin = (iH_Cont >= H_WIN_LO) && (iH_Cont < H_WIN_HI) &&
                 (iV_Cont >= V_WIN_LO) && (iV_Cont < V_WIN_HI);

  assign hRel      = ADDR_W'(iH_Cont) - ADDR_W'(H_ACT_START - 3);
  assign vRel      = ADDR_W'(iV_Cont) - ADDR_W'(V_ACT_START);
  assign fetchAddr = vRel * ADDR_W'(H_ACT) + hRel;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves nextState unassigned (no latch).
    nextState = S_IDLE;
    if (inWin)            nextState = S_FETCH;
    else if (count != '0) nextState = S_DRAIN;
  end

  assign oWr_ready   = iRST_N && (count < DEPTH_C);
  assign push        = iWr_valid && oWr_ready;
  assign pop         = (nextState == S_DRAIN);
  assign oFifo_level = 3'(count);

  assign oRed   = pixel[23:16];
  assign oGreen = pixel[15:8];
  assign oBlue  = pixel[7:0];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= S_IDLE;
      oMem_addr  <= '0;
      oMem_we    <= 1'b0;
      oMem_wdata <= '0;
      fetchD1    <= 1'b0;
      pixel      <= '0;
    end else begin
      state   <= nextState;
      fetchD1 <= (state == S_FETCH);
      pixel   <= fetchD1 ? iMem_rdata : '0;
      case (nextState)
        S_FETCH: begin
          oMem_addr <= fetchAddr;
          oMem_we   <= 1'b0;
        end
        S_DRAIN: begin
          oMem_addr  <= fifoAddr[rdPtr];
          oMem_wdata <= fifoData[rdPtr];
          oMem_we    <= 1'b1;
        end
        default: oMem_we <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifoAddr[wrPtr] <= iWr_addr;
      fifoData[wrPtr] <= iWr_data;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vPrev      <= '0;
      oFrame_cnt <= '0;
    end else begin
      vPrev <= iV_Cont;
      if ((vPrev != 10'd0) && (iV_Cont == 10'd0)) oFrame_cnt <= oFrame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a table of fetch-address vectors followed
// by hand-written sequences for pixel latency, FIFO drain, reset and frame count.
module tb_vga_fb_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [9:0]  iH_Cont, iV_Cont;
  logic        iWr_valid;
  logic        oWr_ready;
  logic [18:0] iWr_addr;
  logic [23:0] iWr_data;
  logic [18:0] oMem_addr;
  logic        oMem_we;
  logic [23:0] oMem_wdata;
  logic [23:0] iMem_rdata;
  logic [7:0]  oRed, oGreen, oBlue;
  logic [2:0]  oFifo_level;
  logic [7:0]  oFrame_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [18:0] expAddr;
  } vec_t;

  vec_t vecs [11];

  vga_fb_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
    .iWr_valid(iWr_valid), .oWr_ready(oWr_ready), .iWr_addr(iWr_addr), .iWr_data(iWr_data),
    .oMem_addr(oMem_addr), .oMem_we(oMem_we), .oMem_wdata(oMem_wdata), .iMem_rdata(iMem_rdata),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oFifo_level(oFifo_level), .oFrame_cnt(oFrame_cnt)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push_write(input logic [18:0] a, input logic [23:0] d);
    iWr_valid = 1'b1;
    iWr_addr  = a;
    iWr_data  = d;
    #1;
    check("ready_before_push", 32'(oWr_ready), 32'd1);
    tick();
    iWr_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10'd137, 10'd34,  19'd0};
    vecs[1]  = '{10'd138, 10'd34,  19'd1};
    vecs[2]  = '{10'd776, 10'd34,  19'd639};
    vecs[3]  = '{10'd137, 10'd35,  19'd640};
    vecs[4]  = '{10'd776, 10'd513, 19'd307199};
    vecs[5]  = '{10'd777, 10'd513, 19'd307199};
    vecs[6]  = '{10'd136, 10'd100, 19'd307199};
    vecs[7]  = '{10'd200, 10'd33,  19'd307199};
    vecs[8]  = '{10'd200, 10'd514, 19'd307199};
    vecs[9]  = '{10'd500, 10'd300, 19'd170603};
    vecs[10] = '{10'd0,   10'd0,   19'd170603};

    iRST_N     = 1'b0;
    iH_Cont    = 10'd0;
    iV_Cont    = 10'd100;
    iWr_valid  = 1'b1;
    iWr_addr   = 19'd3;
    iWr_data   = 24'h0;
    iMem_rdata = 24'h0;
    #12;
    check("rst_ready", 32'(oWr_ready), 32'd0);
    check("rst_we", 32'(oMem_we), 32'd0);
    check("rst_addr", 32'(oMem_addr), 32'd0);
    check("rst_wdata", 32'(oMem_wdata), 32'd0);
    check("rst_colour", {8'd0, oRed, oGreen, oBlue}, 32'd0);
    check("rst_level", 32'(oFifo_level), 32'd0);
    check("rst_frame", 32'(oFrame_cnt), 32'd0);
    iWr_valid = 1'b0;
    #10 iRST_N = 1'b1;
    tick();

    // Fetch-address table: out-of-window vectors must hold the last address.
    for (int i = 0; i < 11; i++) begin
      iH_Cont = vecs[i].h;
      iV_Cont = vecs[i].v;
      tick();
      check($sformatf("vec%0d_addr", i), 32'(oMem_addr), 32'(vecs[i].expAddr));
      check($sformatf("vec%0d_we", i), 32'(oMem_we), 32'd0);
    end

    // First pixel: address at H=137, colour visible at H=140.
    iMem_rdata = 24'hFF8000;
    iH_Cont = 10'd137; iV_Cont = 10'd34;
    tick();
    check("px0_addr", 32'(oMem_addr), 32'd0);
    iH_Cont = 10'd138;
    tick();
    check("px0_not_early", {8'd0, oRed, oGreen, oBlue}, 32'd0);
    iH_Cont = 10'd139;
    tick();
    iH_Cont = 10'd140;
    check("px0_red", 32'(oRed), 32'hFF);
    check("px0_green", 32'(oGreen), 32'h80);
    check("px0_blue", 32'(oBlue), 32'h00);

    // Last pixel of frame, then window closes.
    iMem_rdata = 24'h123456;
    iH_Cont = 10'd776; iV_Cont = 10'd513;
    tick();
    check("last_addr", 32'(oMem_addr), 32'd307199);
    iH_Cont = 10'd777;
    tick();
    check("after_win_we", 32'(oMem_we), 32'd0);
    check("after_win_addr", 32'(oMem_addr), 32'd307199);
    iH_Cont = 10'd778;
    tick();
    iH_Cont = 10'd779;
    check("last_px", {8'd0, oRed, oGreen, oBlue}, 32'h123456);
    tick();
    iH_Cont = 10'd780;
    check("blank_px", {8'd0, oRed, oGreen, oBlue}, 32'd0);

    // Fill FIFO during active line; fifth write is held; drain in blanking.
    iH_Cont = 10'd200; iV_Cont = 10'd100;
    for (int i = 0; i < 4; i++) push_write(19'(5 + i), 24'hA00000 + 24'(i));
    check("full_level", 32'(oFifo_level), 32'd4);
    check("full_ready", 32'(oWr_ready), 32'd0);
    check("full_we", 32'(oMem_we), 32'd0);
    iWr_valid = 1'b1; iWr_addr = 19'd9; iWr_data = 24'hBADBAD;
    tick();
    check("held_level", 32'(oFifo_level), 32'd4);
    iWr_valid = 1'b0;
    iH_Cont = 10'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain%0d_we", i), 32'(oMem_we), 32'd1);
      check($sformatf("drain%0d_addr", i), 32'(oMem_addr), 32'(5 + i));
      check($sformatf("drain%0d_data", i), 32'(oMem_wdata), 32'h00A00000 + 32'(i));
      check($sformatf("drain%0d_level", i), 32'(oFifo_level), 32'(3 - i));
    end
    tick();
    check("drained_we", 32'(oMem_we), 32'd0);
    check("drained_addr_hold", 32'(oMem_addr), 32'd8);

    // Simultaneous push and pop at level 2.
    iH_Cont = 10'd200;
    push_write(19'h10, 24'h111111);
    push_write(19'h11, 24'h222222);
    iH_Cont = 10'd0;
    iWr_valid = 1'b1; iWr_addr = 19'h12; iWr_data = 24'h333333;
    #1;
    check("pp_ready", 32'(oWr_ready), 32'd1);
    tick();
    iWr_valid = 1'b0;
    check("pp_level", 32'(oFifo_level), 32'd2);
    check("pp_we", 32'(oMem_we), 32'd1);
    check("pp_addr", 32'(oMem_addr), 32'h10);
    check("pp_data", 32'(oMem_wdata), 32'h111111);
    tick();
    check("pp_addr2", 32'(oMem_addr), 32'h11);
    tick();
    check("pp_addr3", 32'(oMem_addr), 32'h12);
    check("pp_data3", 32'(oMem_wdata), 32'h333333);
    tick();
    check("pp_idle_we", 32'(oMem_we), 32'd0);

    // Reset mid-drain discards the remaining writes.
    iH_Cont = 10'd200;
    for (int i = 0; i < 4; i++) push_write(19'h20 + 19'(i), 24'h440000 + 24'(i));
    iH_Cont = 10'd0;
    tick();
    check("mid_drain_we", 32'(oMem_we), 32'd1);
    check("mid_drain_level", 32'(oFifo_level), 32'd3);
    #2 iRST_N = 1'b0;
    #1;
    check("rst_mid_we", 32'(oMem_we), 32'd0);
    check("rst_mid_level", 32'(oFifo_level), 32'd0);
    check("rst_mid_addr", 32'(oMem_addr), 32'd0);
    check("rst_mid_ready", 32'(oWr_ready), 32'd0);
    @(posedge iCLK);
    #3 iRST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst%0d_we", i), 32'(oMem_we), 32'd0);
    end
    check("post_rst_level", 32'(oFifo_level), 32'd0);
    check("post_rst_ready", 32'(oWr_ready), 32'd1);

    // Frame counter.
    check("frame_start", 32'(oFrame_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      iV_Cont = 10'd528; tick();
      iV_Cont = 10'd0;   tick();
    end
    check("frame_3", 32'(oFrame_cnt), 32'd3);
    tick();
    check("frame_hold_at_0", 32'(oFrame_cnt), 32'd3);
    for (int i = 0; i < 252; i++) begin
      iV_Cont = 10'd1; tick();
      iV_Cont = 10'd0; tick();
    end
    check("frame_255", 32'(oFrame_cnt), 32'd255);
    iV_Cont = 10'd528; tick();
    iV_Cont = 10'd0;   tick();
    check("frame_wrap", 32'(oFrame_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
